// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//
// Runs one logic-analyzer acquisition into a circular capture RAM. The phases
// are pre-trigger fill, armed wait, post-trigger count, readout hold and a
// timed memory clear. The block sits between the sample-rate strobe, the
// trigger unit and the host readout logic.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   locked     asynchronous active-low reset (clock-manager locked)
//   Start      1-cycle pulse, begin an acquisition (IDLE only)
//   Abort      1-cycle pulse, cancel an acquisition
//   PreDepth   pre-trigger samples required before arming
//   PostDepth  samples stored after the trigger sample
//   TmoLimit   armed-state auto-trigger limit in samples (timeout build only)
//   SampleEn   sample strobe from the rate divider
//   Trig       trigger match from the trigger unit
//   RdAck      1-cycle pulse, host finished reading
//   WrEn       capture RAM write strobe
//   WrAddr     capture RAM write address (value used by the current write)
//   ENTrig     trigger unit enable
//   TrigAddr   RAM address that holds the trigger sample
//   StartAddr  oldest valid sample address
//   Done       acquisition complete, RAM stable for readout
//   ClrMem     clear strobe to capture RAM / FIFO
//   TimedOut   trigger was forced by the armed-state timeout
//   state      encoded sequencer state
//
// Build option
//   TRIG_TIMEOUT_EN  when defined, ARMED counts samples and forces a trigger
//                    once TmoLimit samples have gone by without a match.
//                    Otherwise ARMED waits indefinitely and TimedOut stays 0.
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | IDLE   waiting for Start
//   1   | PRE    filling the pre-trigger window
//   2   | ARMED  circular writes, trigger unit enabled
//   3   | POST   storing the post-trigger samples
//   4   | DONE   RAM stable, waiting for RdAck
//   5   | CLEAR  ClrMem held for CLR_CYC cycles
// -----------------------------------------------------------------------------
module capture_sequencer #(
    parameter int AW      = 10,
    parameter int CLR_CYC = 11,
    parameter int TMO_W   = 16
) (
    input  logic             CLK,
    input  logic             locked,
    input  logic             Start,
    input  logic             Abort,
    input  logic [AW-1:0]    PreDepth,
    input  logic [AW-1:0]    PostDepth,
    input  logic [TMO_W-1:0] TmoLimit,
    input  logic             SampleEn,
    input  logic             Trig,
    input  logic             RdAck,
    output logic             WrEn,
    output logic [AW-1:0]    WrAddr,
    output logic             ENTrig,
    output logic [AW-1:0]    TrigAddr,
    output logic [AW-1:0]    StartAddr,
    output logic             Done,
    output logic             ClrMem,
    output logic             TimedOut,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    localparam logic [AW-1:0] MAX_ADDR = {AW{1'b1}};
    localparam int CLR_CW = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC + 1);
    localparam logic [CLR_CW-1:0] CLR_LOAD = CLR_CW'(CLR_CYC - 1);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [AW-1:0]      trig_addr_q, trig_addr_d;
    logic [AW-1:0]      start_addr_q, start_addr_d;
    logic [AW-1:0]      pre_eff_q, pre_eff_d;
    logic [AW-1:0]      post_eff_q, post_eff_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [CLR_CW-1:0]  clr_cnt_q, clr_cnt_d;
    logic               timed_out_q, timed_out_d;

    logic               wr_en;
    logic [AW-1:0]      pre_sel;
    logic [AW-1:0]      post_room;
    logic [AW-1:0]      post_sel;
    logic [AW-1:0]      cnt_inc;
    logic               tmo_hit;

`ifdef TRIG_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W:0]     tmo_next;

    // Extra bit so a TmoLimit of all ones is still reachable.
    assign tmo_next = {1'b0, tmo_cnt_q} + (TMO_W + 1)'(1);
    assign tmo_hit  = SampleEn && (TmoLimit != '0) && (tmo_next == {1'b0, TmoLimit});
`else
    logic unused_tmo_limit;

    assign unused_tmo_limit = ^TmoLimit;
    assign tmo_hit          = 1'b0;
`endif

    // An AW-bit PreDepth can never exceed DEPTH-1, so it is used as-is;
    // PostDepth is clipped to what fits behind the pre-trigger window.
    assign pre_sel   = PreDepth;
    assign post_room = MAX_ADDR - pre_sel;
    assign post_sel  = (PostDepth > post_room) ? post_room : PostDepth;

    assign wr_en   = SampleEn &&
                     ((state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST));
    assign cnt_inc = cnt_q + AW'(1);

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        pre_eff_d    = pre_eff_q;
        post_eff_d   = post_eff_q;
        cnt_d        = cnt_q;
        clr_cnt_d    = clr_cnt_q;
        timed_out_d  = timed_out_q;
`ifdef TRIG_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        // A write issued in an Abort cycle still advances the address.
        if (wr_en) begin
            wr_addr_d = wr_addr_q + AW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    pre_eff_d   = pre_sel;
                    post_eff_d  = post_sel;
                    wr_addr_d   = '0;
                    cnt_d       = '0;
                    clr_cnt_d   = '0;
                    timed_out_d = 1'b0;
`ifdef TRIG_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                    state_d     = (pre_sel == '0) ? S_ARMED : S_PRE;
                end
            end

            S_PRE: begin
                if (Abort) begin
                    clr_cnt_d = CLR_LOAD;
                    state_d   = S_CLEAR;
                end else if (wr_en) begin
                    if (cnt_inc == pre_eff_q) begin
                        cnt_d   = '0;
`ifdef TRIG_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_ARMED: begin
                if (Abort) begin
                    clr_cnt_d = CLR_LOAD;
                    state_d   = S_CLEAR;
                end else if (wr_en) begin
`ifdef TRIG_TIMEOUT_EN
                    tmo_cnt_d = tmo_next[TMO_W-1:0];
`endif
                    // The sample written this cycle is the trigger sample.
                    if (Trig || tmo_hit) begin
                        trig_addr_d  = wr_addr_q;
                        start_addr_d = wr_addr_q - pre_eff_q;
                        cnt_d        = '0;
                        timed_out_d  = tmo_hit && !Trig;
                        state_d      = (post_eff_q == '0) ? S_DONE : S_POST;
                    end
                end
            end

            S_POST: begin
                if (Abort) begin
                    clr_cnt_d = CLR_LOAD;
                    state_d   = S_CLEAR;
                end else if (wr_en) begin
                    if (cnt_inc == post_eff_q) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_DONE: begin
                if (Abort || RdAck) begin
                    clr_cnt_d = CLR_LOAD;
                    state_d   = S_CLEAR;
                end
            end

            S_CLEAR: begin
                if (clr_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q - CLR_CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge locked) begin
        if (!locked) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            pre_eff_q    <= '0;
            post_eff_q   <= '0;
            cnt_q        <= '0;
            clr_cnt_q    <= '0;
            timed_out_q  <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            pre_eff_q    <= pre_eff_d;
            post_eff_q   <= post_eff_d;
            cnt_q        <= cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            timed_out_q  <= timed_out_d;
`ifdef TRIG_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign WrEn      = wr_en;
    assign WrAddr    = wr_addr_q;
    assign ENTrig    = (state_q == S_ARMED);
    assign TrigAddr  = trig_addr_q;
    assign StartAddr = start_addr_q;
    assign Done      = (state_q == S_DONE);
    assign ClrMem    = (state_q == S_CLEAR);
    assign TimedOut  = timed_out_q;
    assign state     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;

    logic        CLK = 1'b0;
    logic        locked = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [3:0]  PreDepth = 4'd0;
    logic [3:0]  PostDepth = 4'd0;
    logic [15:0] TmoLimit = 16'd0;
    logic        SampleEn = 1'b0;
    logic        Trig = 1'b0;
    logic        RdAck = 1'b0;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic        ENTrig;
    logic [3:0]  TrigAddr;
    logic [3:0]  StartAddr;
    logic        Done;
    logic        ClrMem;
    logic        TimedOut;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    logic done_seen;

    capture_sequencer #(.AW(4), .CLR_CYC(4), .TMO_W(16)) dut (
        .CLK(CLK), .locked(locked), .Start(Start), .Abort(Abort),
        .PreDepth(PreDepth), .PostDepth(PostDepth), .TmoLimit(TmoLimit),
        .SampleEn(SampleEn), .Trig(Trig), .RdAck(RdAck),
        .WrEn(WrEn), .WrAddr(WrAddr), .ENTrig(ENTrig), .TrigAddr(TrigAddr),
        .StartAddr(StartAddr), .Done(Done), .ClrMem(ClrMem),
        .TimedOut(TimedOut), .state(state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic       st, ab, sen, tr, ra;
        logic [2:0] e_state;
        logic       e_wren;
        logic [3:0] e_wraddr;
        logic       e_entrig, e_done, e_clr;
        logic [3:0] e_trig, e_start;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, ab, sen, tr, ra,
                       input logic [2:0] es, input logic ew, input logic [3:0] ea,
                       input logic et, ed, ec, input logic [3:0] eta, esa);
        vec_t v;
        v.st = st; v.ab = ab; v.sen = sen; v.tr = tr; v.ra = ra;
        v.e_state = es; v.e_wren = ew; v.e_wraddr = ea;
        v.e_entrig = et; v.e_done = ed; v.e_clr = ec;
        v.e_trig = eta; v.e_start = esa;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are observed 1 ns later,
    // before the rising edge that consumes these inputs.
    task automatic drive(input logic st, ab, sen, tr, ra);
        @(negedge CLK);
        Start = st; Abort = ab; SampleEn = sen; Trig = tr; RdAck = ra;
        #1;
        if (Done) done_seen = 1'b1;
    endtask

    task automatic check_clear(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0, 0);
            if (ClrMem) n++;
            if (state == 3'd0 && !ClrMem) break;
        end
        chk({name, "_clr_len"}, n, 4);
        chk({name, "_idle"}, state, 0);
    endtask

    initial begin
        done_seen = 1'b0;

        // Reset values
        #2;
        chk("rst_state", state, 0);
        chk("rst_wraddr", WrAddr, 0);
        chk("rst_outs", {WrEn, ENTrig, Done, ClrMem, TimedOut}, 0);
        chk("rst_addrs", {TrigAddr, StartAddr}, 0);
        @(negedge CLK);
        locked = 1'b1;

        // Scenario 1: pre=3 post=4, trigger on 6th sample, Start ignored in
        // DONE, RdAck clears for 4 cycles.
        //   st ab sen tr ra  state wren addr entrig done clr trig start
        add(1, 0, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  1, 1,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  1, 1,  1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  1, 1,  2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  2, 1,  3, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  2, 1,  4, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0,  2, 1,  5, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0,  3, 1,  6, 0, 0, 0, 5, 2);
        add(0, 0, 1, 0, 0,  3, 1,  7, 0, 0, 0, 5, 2);
        add(0, 0, 1, 0, 0,  3, 1,  8, 0, 0, 0, 5, 2);
        add(0, 0, 1, 0, 0,  3, 1,  9, 0, 0, 0, 5, 2);
        add(1, 0, 1, 0, 0,  4, 0, 10, 0, 1, 0, 5, 2);
        add(0, 0, 1, 0, 1,  4, 0, 10, 0, 1, 0, 5, 2);
        add(0, 0, 1, 0, 0,  5, 0, 10, 0, 0, 1, 5, 2);
        add(0, 0, 1, 0, 0,  5, 0, 10, 0, 0, 1, 5, 2);
        add(0, 0, 1, 0, 0,  5, 0, 10, 0, 0, 1, 5, 2);
        add(0, 0, 1, 0, 0,  5, 0, 10, 0, 0, 1, 5, 2);
        add(0, 0, 1, 0, 0,  0, 0, 10, 0, 0, 0, 5, 2);

        PreDepth = 4'd3; PostDepth = 4'd4;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].sen, vecs[i].tr, vecs[i].ra);
            chk($sformatf("v%0d_state", i), state, vecs[i].e_state);
            chk($sformatf("v%0d_wren", i), WrEn, vecs[i].e_wren);
            chk($sformatf("v%0d_wraddr", i), WrAddr, vecs[i].e_wraddr);
            chk($sformatf("v%0d_entrig", i), ENTrig, vecs[i].e_entrig);
            chk($sformatf("v%0d_done", i), Done, vecs[i].e_done);
            chk($sformatf("v%0d_clr", i), ClrMem, vecs[i].e_clr);
            chk($sformatf("v%0d_trigaddr", i), TrigAddr, vecs[i].e_trig);
            chk($sformatf("v%0d_startaddr", i), StartAddr, vecs[i].e_start);
        end

        // Scenario 2: pre=10 post=10 -> PostEff=5, address wrap.
        PreDepth = 4'd10; PostDepth = 4'd10;
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 0, 0);
            chk($sformatf("s2_pre%0d_addr", i), WrAddr, i);
            chk($sformatf("s2_pre%0d_state", i), state, 1);
        end
        drive(0, 0, 1, 1, 0);
        chk("s2_arm_state", state, 2);
        chk("s2_arm_addr", WrAddr, 10);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0);
            chk($sformatf("s2_post%0d_state", i), state, 3);
            chk($sformatf("s2_post%0d_addr", i), WrAddr, 11 + i);
        end
        drive(0, 0, 1, 0, 0);
        chk("s2_done_state", state, 4);
        chk("s2_done_wraddr", WrAddr, 0);
        chk("s2_done_wren", WrEn, 0);
        chk("s2_trigaddr", TrigAddr, 10);
        chk("s2_startaddr", StartAddr, 0);
        drive(0, 0, 1, 0, 1);
        check_clear("s2");

        // Scenario 3: pre=2, trigger on the 23rd sample, plus a Trig pulse
        // without SampleEn that must be ignored.
        PreDepth = 4'd2; PostDepth = 4'd1;
        drive(1, 0, 1, 0, 0);
        for (int k = 1; k <= 22; k++) begin
            if (k == 10) begin
                drive(0, 0, 0, 1, 0);
                chk("s3_nosample_wren", WrEn, 0);
            end
            drive(0, 0, 1, 0, 0);
            if (k == 10) begin
                chk("s3_nosample_state", state, 2);
                chk("s3_nosample_addr", WrAddr, 9);
            end
        end
        drive(0, 0, 1, 1, 0);
        chk("s3_trig_state", state, 2);
        chk("s3_trig_addr", WrAddr, 6);
        drive(0, 0, 1, 0, 0);
        chk("s3_post_state", state, 3);
        drive(0, 0, 1, 0, 0);
        chk("s3_done_state", state, 4);
        chk("s3_done_wraddr", WrAddr, 8);
        chk("s3_trigaddr", TrigAddr, 6);
        chk("s3_startaddr", StartAddr, 4);
        drive(0, 1, 0, 0, 0);
        check_clear("s3");

        // Scenario 4: Abort during POST, write still issued, Done never seen.
        PreDepth = 4'd3; PostDepth = 4'd4;
        drive(1, 0, 1, 0, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        chk("s4_abort_state", state, 3);
        chk("s4_abort_wren", WrEn, 1);
        check_clear("s4");
        chk("s4_done_seen", done_seen, 0);

        // Scenario 5: reset mid-ARMED.
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("s5_armed", state, 2);
        #2 locked = 1'b0;
        #1;
        chk("s5_rst_state", state, 0);
        chk("s5_rst_wraddr", WrAddr, 0);
        chk("s5_rst_outs", {WrEn, ENTrig, Done, ClrMem, TimedOut}, 0);
        chk("s5_rst_trigaddr", TrigAddr, 0);
        @(negedge CLK);
        locked = 1'b1;
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("s5_after_state", state, 0);
        chk("s5_after_clr", ClrMem, 0);

        // Scenario 6: PreEff=0, Start+Abort together, armed timeout.
        PreDepth = 4'd0; PostDepth = 4'd2; TmoLimit = 16'd8;
        drive(1, 1, 1, 0, 0);
        chk("s6_start_wren", WrEn, 0);
        drive(0, 0, 1, 0, 0);
        chk("s6_armed_state", state, 2);
        chk("s6_armed_addr", WrAddr, 0);
        for (int i = 1; i < 8; i++) begin
            drive(0, 0, 1, 0, 0);
            chk($sformatf("s6_arm%0d_state", i), state, 2);
        end
        drive(0, 0, 1, 0, 0);
`ifdef TRIG_TIMEOUT_EN
        chk("s6_tmo_state", state, 3);
        chk("s6_tmo_flag", TimedOut, 1);
        chk("s6_tmo_trigaddr", TrigAddr, 7);
        chk("s6_tmo_startaddr", StartAddr, 7);
        chk("s6_tmo_wraddr", WrAddr, 8);
`else
        chk("s6_notmo_state", state, 2);
        chk("s6_notmo_flag", TimedOut, 0);
`endif
        drive(0, 1, 1, 0, 0);
        check_clear("s6");
`ifdef TRIG_TIMEOUT_EN
        chk("s6_flag_held", TimedOut, 1);
`else
        chk("s6_flag_held", TimedOut, 0);
`endif
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("s6_restart_state", state, 2);
        chk("s6_restart_flag", TimedOut, 0);
        drive(0, 1, 1, 0, 0);
        check_clear("s6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
